// File: rtl/estagio_memoria_pkg.sv
// Shared types for the halfword data-memory stage: FSM encoding, halfword width
// and the sign-extension used on load write-back.
package estagio_memoria_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    localparam int HALF_W = 16;

    function automatic logic [31:0] estende_sinal(input logic [HALF_W-1:0] h);
        return {{(32-HALF_W){h[HALF_W-1]}}, h};
    endfunction

endpackage

// File: rtl/ram_bytes.sv
// Byte-addressed RAM with a two-byte (little-endian halfword) write port and a
// registered halfword read; a+1 wraps inside ADDR_BITS so no access straddles the top.
module ram_bytes
    import estagio_memoria_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic [1:0]           we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [HALF_W-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [HALF_W-1:0]    rdata
);

    localparam int                   DEPTH    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] UM       = 1;
    localparam logic [7:0]           INIT_VAL = INIT_ZERO ? 8'h00 : 8'hxx;

    logic [7:0] mem [DEPTH] = '{default: INIT_VAL};

    logic [ADDR_BITS-1:0] waddr_1;
    logic [ADDR_BITS-1:0] raddr_1;

    assign waddr_1 = waddr + UM;
    assign raddr_1 = raddr + UM;

    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr]   <= wdata[7:0];
        if (we[1]) mem[waddr_1] <= wdata[15:8];
        rdata <= {mem[raddr_1], mem[raddr]};
    end

endmodule

// File: rtl/estagio_memoria.sv
// Memory stage for lh/sh: OCIOSO -> ACESSO -> RESPOSTA, pronto two cycles after inicio.
// inicio is ignored while ocupado; errors suppress the RAM write and the load update.
module estagio_memoria
    import estagio_memoria_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inicio,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_escrita,
    output logic [31:0] dado_lido,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro_alinhamento,
    output logic        erro_operacao
);

    estado_t estado, prox;

    logic [ADDR_BITS-1:0] addr_q;
    logic [HALF_W-1:0]    dado_q;
    logic                 rd_q, wr_q;
    logic                 erro_al_q, erro_op_q;

    logic                 erro_op_c, erro_al_c, acesso_ok;
    logic [1:0]           we;
    logic [ADDR_BITS-1:0] raddr;
    logic [HALF_W-1:0]    rdata;

    logic unused_bits;
    assign unused_bits = ^{endereco[31:ADDR_BITS], dado_escrita[31:HALF_W]};

    always_comb begin
        prox      = estado;
        erro_op_c = (rd_q == wr_q);
        erro_al_c = ~erro_op_c & addr_q[0];
        acesso_ok = 1'b0;
        we        = 2'b00;
        case (estado)
            OCIOSO:   if (inicio) prox = ACESSO;
            ACESSO: begin
                acesso_ok = ~erro_op_c & ~addr_q[0];
                if (acesso_ok && wr_q) we = 2'b11;
                prox = RESPOSTA;
            end
            RESPOSTA: prox = OCIOSO;
            default:  prox = OCIOSO;
        endcase
    end

    // The RAM read is launched from the live address on the accept edge so the
    // halfword is already registered by the time ACESSO commits it.
    assign raddr = (estado == OCIOSO) ? endereco[ADDR_BITS-1:0] : addr_q;

    ram_bytes #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q),
        .wdata (dado_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            addr_q    <= '0;
            dado_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            erro_al_q <= 1'b0;
            erro_op_q <= 1'b0;
            dado_lido <= '0;
        end else begin
            estado <= prox;
            if (estado == OCIOSO && inicio) begin
                addr_q <= endereco[ADDR_BITS-1:0];
                dado_q <= dado_escrita[HALF_W-1:0];
                rd_q   <= MemRead;
                wr_q   <= MemWrite;
            end
            if (estado == ACESSO) begin
                erro_al_q <= erro_al_c;
                erro_op_q <= erro_op_c;
                if (acesso_ok && rd_q) dado_lido <= estende_sinal(rdata);
            end
        end
    end

    assign ocupado          = (estado != OCIOSO);
    assign pronto           = (estado == RESPOSTA);
    assign erro_alinhamento = pronto & erro_al_q;
    assign erro_operacao    = pronto & erro_op_q;

endmodule

// File: tb/tb_estagio_memoria.sv
// Directed bench for estagio_memoria: store/load, errors, wrap, busy and reset aborts.
module tb_estagio_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] endereco;
    logic [31:0] dado_escrita;
    logic [31:0] dado_lido;
    logic        ocupado;
    logic        pronto;
    logic        erro_alinhamento;
    logic        erro_operacao;

    int checks = 0;
    int errors = 0;

    estagio_memoria #(.ADDR_BITS(10), .INIT_ZERO(1'b1)) dut (
        .clk              (clk),
        .reset            (reset),
        .inicio           (inicio),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .endereco         (endereco),
        .dado_escrita     (dado_escrita),
        .dado_lido        (dado_lido),
        .ocupado          (ocupado),
        .pronto           (pronto),
        .erro_alinhamento (erro_alinhamento),
        .erro_operacao    (erro_operacao)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full operation; inputs are scrambled after the accept edge to show
    // only the sampled values matter.
    task automatic do_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic ea, input logic eo, input logic [31:0] edado);
        int n;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; endereco = a; dado_escrita = d; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0; MemRead = ~rd; MemWrite = ~wr; endereco = ~a; dado_escrita = ~d;
        n = 1;
        while (!pronto && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_al"}, {31'b0, erro_alinhamento}, {31'b0, ea});
        chk({tag, "_op"}, {31'b0, erro_operacao}, {31'b0, eo});
        chk({tag, "_dado"}, dado_lido, edado);
        @(posedge clk); #1;
        chk({tag, "_pulso"}, {31'b0, pronto}, 32'd0);
        chk({tag, "_livre"}, {31'b0, ocupado}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npronto;
        reset = 1'b1; inicio = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        endereco = '0; dado_escrita = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dado", dado_lido, 32'd0);
        chk("rst_ocupado", {31'b0, ocupado}, 32'd0);
        chk("rst_pronto", {31'b0, pronto}, 32'd0);
        chk("rst_flags", {30'b0, erro_alinhamento, erro_operacao}, 32'd0);
        @(negedge clk) reset = 1'b0;

        do_op("sh10",    1'b0, 1'b1, 32'h10, 32'h1234ABCD, 1'b0, 1'b0, 32'h0);
        do_op("lh10",    1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'hFFFFABCD);
        do_op("sh10b",   1'b0, 1'b1, 32'h10, 32'h00007FFF, 1'b0, 1'b0, 32'hFFFFABCD);
        do_op("lh10b",   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h00007FFF);
        do_op("sh11",    1'b0, 1'b1, 32'h11, 32'h0000BEEF, 1'b1, 1'b0, 32'h00007FFF);
        do_op("lh10c",   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h00007FFF);
        do_op("rw21",    1'b1, 1'b1, 32'h21, 32'h5555,     1'b0, 1'b1, 32'h00007FFF);
        do_op("nop11",   1'b0, 1'b0, 32'h11, 32'h6666,     1'b0, 1'b1, 32'h00007FFF);
        do_op("rw10",    1'b1, 1'b1, 32'h10, 32'h3333,     1'b0, 1'b1, 32'h00007FFF);
        do_op("lh10d",   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h00007FFF);
        do_op("sh402",   1'b0, 1'b1, 32'h402, 32'h8001,    1'b0, 1'b0, 32'h00007FFF);
        do_op("lh002",   1'b1, 1'b0, 32'h002, 32'h0,       1'b0, 1'b0, 32'hFFFF8001);
        do_op("sh3fe",   1'b0, 1'b1, 32'h3FE, 32'h1357,    1'b0, 1'b0, 32'hFFFF8001);
        do_op("lh7fe",   1'b1, 1'b0, 32'h7FE, 32'h0,       1'b0, 1'b0, 32'h00001357);
        do_op("lh000",   1'b1, 1'b0, 32'h000, 32'h0,       1'b0, 1'b0, 32'h00000000);

        // inicio held high through ACESSO and RESPOSTA must yield a single operation
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; endereco = 32'h30; dado_escrita = 32'h4444; inicio = 1'b1;
        npronto = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (pronto) npronto++;
            if (i == 0) chk("busy_ocupado", {31'b0, ocupado}, 32'd1);
            if (i == 2) inicio = 1'b0;
        end
        chk("busy_npronto", 32'(npronto), 32'd1);
        do_op("lh30",    1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 1'b0, 32'h00004444);

        // reset during ACESSO: no store, no pronto, outputs clear asynchronously
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; endereco = 32'h10; dado_escrita = 32'hAAAA; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        chk("abort_ocupado", {31'b0, ocupado}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_rst_ocupado", {31'b0, ocupado}, 32'd0);
        chk("abort_rst_pronto", {31'b0, pronto}, 32'd0);
        chk("abort_rst_dado", dado_lido, 32'd0);
        @(negedge clk) reset = 1'b0;
        npronto = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (pronto) npronto++;
        end
        chk("abort_npronto", 32'(npronto), 32'd0);
        do_op("lh10e",   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h00007FFF);

        // reset during RESPOSTA drops pronto and clears dado_lido immediately
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; endereco = 32'h30; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        @(posedge clk); #1;
        chk("resp_pronto", {31'b0, pronto}, 32'd1);
        chk("resp_dado", dado_lido, 32'h00004444);
        #1 reset = 1'b1;
        #1;
        chk("resp_rst_pronto", {31'b0, pronto}, 32'd0);
        chk("resp_rst_ocupado", {31'b0, ocupado}, 32'd0);
        chk("resp_rst_dado", dado_lido, 32'd0);
        @(negedge clk) reset = 1'b0;
        do_op("lh002b",  1'b1, 1'b0, 32'h002, 32'h0,       1'b0, 1'b0, 32'hFFFF8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
